dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 118 +++++++++++
 tb/tb_dmem_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with fixed access latency over valid/ready handshakes
// Optional `DMEM_RESP_ERR_EN flags misaligned and out-of-range accesses instead of wrapping them.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_write;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH];

  logic          w_accept;
  logic          w_fire;
  logic          w_acc_write;
  logic [31:0]   w_acc_addr;
  logic [31:0]   w_acc_wdata;
  logic [3:0]    w_acc_wstrb;
  logic [AW-1:0] w_acc_idx;
  logic          w_acc_err;

  assign w_accept = (r_state == S_IDLE) && req_valid_i;
  // With LATENCY==1 the access happens on the acceptance edge, straight from the request inputs.
  assign w_fire   = (w_accept && (LATENCY == 1)) || ((r_state == S_WAIT) && (r_cnt == CW'(1)));

  assign w_acc_write = (r_state == S_IDLE) ? req_write_i : r_write;
  assign w_acc_addr  = (r_state == S_IDLE) ? req_addr_i  : r_addr;
  assign w_acc_wdata = (r_state == S_IDLE) ? req_wdata_i : r_wdata;
  assign w_acc_wstrb = (r_state == S_IDLE) ? req_wstrb_i : r_wstrb;
  assign w_acc_idx   = w_acc_addr[AW+1:2];

`ifdef DMEM_RESP_ERR_EN
  assign w_acc_err = (w_acc_addr[1:0] != 2'b00) || (w_acc_addr[31:AW+2] != '0);
`else
  assign w_acc_err = 1'b0;
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{w_acc_addr[1:0], w_acc_addr[31:AW+2]};
`endif

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_write <= req_write_i;
      r_addr  <= req_addr_i;
      r_wdata <= req_wdata_i;
      r_wstrb <= req_wstrb_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_fire) begin
        r_rdata <= (w_acc_write || w_acc_err) ? 32'd0 : r_mem[w_acc_idx];
        r_err   <= w_acc_err;
      end
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_cnt   <= CW'(LATENCY - 1);
            r_state <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage is never cleared; reset only suppresses a pending commit.
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_fire && w_acc_write && !w_acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_acc_wstrb[b]) r_mem[w_acc_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
      end
    end
  end

  assign req_ready_o  = (r_state == S_IDLE);
  assign resp_valid_o = (r_state == S_RESP);
  assign resp_rdata_o = r_rdata;
  assign resp_err_o   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder against a word-array reference model
module tb_dmem_responder;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_write_i = 1'b0;
  logic [31:0] req_addr_i = 32'd0;
  logic [31:0] req_wdata_i = 32'd0;
  logic [3:0]  req_wstrb_i = 4'd0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem_m [DEPTH];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_err(input logic [31:0] addr);
`ifdef DMEM_RESP_ERR_EN
    return (addr % 4 != 0) || (addr >= 32'(DEPTH * 4));
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input int hold,
                        output logic [31:0] rd, output logic er);
    int cyc;
    int w;
    logic [31:0] held;
    w = 0;
    @(negedge clk_i);
    while (!req_ready_o && w < 20) begin
      @(negedge clk_i);
      w++;
    end
    chk("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wd;
    req_wstrb_i = st;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    cyc = 1;
    chk("req_ready_busy", {31'd0, req_ready_o}, 32'd0);
    while (!resp_valid_o && cyc < 50) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("latency", cyc, LATENCY);
    rd = resp_rdata_o;
    er = resp_err_o;
    held = resp_rdata_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      chk("hold_valid", {31'd0, resp_valid_o}, 32'd1);
      chk("hold_rdata", resp_rdata_o, held);
      chk("hold_ready", {31'd0, req_ready_o}, 32'd0);
    end
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    #1 resp_ready_i = 1'b0;
    @(negedge clk_i);
    chk("idle_after_resp", {31'd0, req_ready_o}, 32'd1);
    chk("valid_after_resp", {31'd0, resp_valid_o}, 32'd0);
  endtask

  task automatic op(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                    input logic [3:0] st, input int hold, output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_er;
    int          idx;
    exp_er = m_err(addr);
    idx    = int'((addr / 4) % DEPTH);
    exp_rd = (wr || exp_er) ? 32'd0 : mem_m[idx];
    do_req(wr, addr, wd, st, hold, rd, er);
    chk("rdata", rd, exp_rd);
    chk("err", {31'd0, er}, {31'd0, exp_er});
    if (wr && !exp_er) begin
      for (int b = 0; b < 4; b++) begin
        if (st[b]) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    int          r;

    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_rdata", resp_rdata_o, 32'd0);
    chk("rst_err", {31'd0, resp_err_o}, 32'd0);

    for (int i = 0; i < DEPTH; i++) op(1'b1, 32'(i * 4), $urandom, 4'hF, 0, rd, er);

    op(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er);
    op(1'b0, 32'h10, 32'd0, 4'h0, 0, rd, er);
    chk("dir_load_10", rd, 32'hDEADBEEF);

    op(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er);
    op(1'b1, 32'h20, 32'h0000AA00, 4'b0010, 0, rd, er);
    op(1'b0, 32'h20, 32'd0, 4'h0, 5, rd, er);
    chk("dir_strb_20", rd, 32'h1122AA44);

    op(1'b1, 32'h30, 32'h0, 4'hF, 0, rd, er);
    op(1'b0, 32'h10, 32'd0, 4'h0, 0, rd, er);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_addr_i  = 32'h30;
    req_wdata_i = 32'h5;
    req_wstrb_i = 4'hF;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("wrst_req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("wrst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("wrst_rdata", resp_rdata_o, 32'd0);
    chk("wrst_err", {31'd0, resp_err_o}, 32'd0);
    op(1'b0, 32'h30, 32'd0, 4'h0, 0, rd, er);
    chk("dir_rst_drop_30", rd, 32'd0);

`ifdef DMEM_RESP_ERR_EN
    op(1'b0, 32'h13, 32'd0, 4'h0, 0, rd, er);
    chk("dir_mis_err", {31'd0, er}, 32'd1);
    chk("dir_mis_rdata", rd, 32'd0);
    op(1'b0, 32'(DEPTH * 4), 32'd0, 4'h0, 0, rd, er);
    chk("dir_oor_err", {31'd0, er}, 32'd1);
    chk("dir_oor_rdata", rd, 32'd0);
    op(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 0, rd, er);
    op(1'b1, 32'(DEPTH * 4), 32'hFFFFFFFF, 4'hF, 0, rd, er);
    op(1'b0, 32'h10, 32'd0, 4'h0, 0, rd, er);
    chk("dir_err_nowrite", rd, 32'hDEADBEEF);
`else
    op(1'b1, 32'(DEPTH * 4 + 8), 32'h77, 4'hF, 0, rd, er);
    op(1'b0, 32'h8, 32'd0, 4'h0, 0, rd, er);
    chk("dir_wrap_rdata", rd, 32'h77);
    chk("dir_wrap_err", {31'd0, er}, 32'd0);
`endif

    for (int n = 0; n < 200; n++) begin
`ifdef DMEM_RESP_ERR_EN
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = ($urandom_range(0, DEPTH * 4 - 1)) | 32'd1;
      else if (r == 1) a = 32'(DEPTH * 4) + ($urandom & 32'h0FFF_FFFC);
      else             a = 32'($urandom_range(0, DEPTH - 1)) * 4;
`else
      r = 0;
      a = $urandom;
`endif
      op(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
         int'($urandom_range(0, 3)) + r * 0, rd, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
